alu_operand_sequencer: RTL

ALU_OPERAND_SEQUENCER -- requirements
Module: alu_operand_sequencer

---
 rtl/alu_operand_sequencer.sv | 93 +++++++++
 1 files changed

// File: rtl/alu_operand_sequencer.sv
// Collects an A/B operand pair for a downstream combinational ALU, captures its
// result and holds it until the consumer completes a valid/ready handshake.
module alu_operand_sequencer #(
   parameter int unsigned N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] op_data,
   input  logic         op_valid,
   output logic         op_ready,
   output logic [N-1:0] alu_in0,
   output logic [N-1:0] alu_in1,
   input  logic [N-1:0] alu_out,
   output logic [N-1:0] res_data,
   output logic         res_valid,
   input  logic         res_ready,
   output logic         busy,
   output logic [7:0]   txn_count
);

   typedef enum logic [1:0] {
      LOAD_A,
      LOAD_B,
      EXEC,
      HOLD
   } state_t;

   state_t       state, state_nxt;
   logic [N-1:0] in0_nxt, in1_nxt, res_nxt;
   logic         rv_nxt;
   logic [7:0]   cnt_nxt;
   logic         accept;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= LOAD_A;
         alu_in0   <= '0;
         alu_in1   <= '0;
         res_data  <= '0;
         res_valid <= 1'b0;
         txn_count <= '0;
      end else begin
         state     <= state_nxt;
         alu_in0   <= in0_nxt;
         alu_in1   <= in1_nxt;
         res_data  <= res_nxt;
         res_valid <= rv_nxt;
         txn_count <= cnt_nxt;
      end
   end

   // op_ready depends on state alone so the producer never sees a valid->ready path.
   assign op_ready = (state == LOAD_A) || (state == LOAD_B);
   assign busy     = (state != LOAD_A);
   assign accept   = op_valid & op_ready;

   always_comb begin
      state_nxt = state;
      in0_nxt   = alu_in0;
      in1_nxt   = alu_in1;
      res_nxt   = res_data;
      rv_nxt    = res_valid;
      cnt_nxt   = txn_count;
      unique case (state)
         LOAD_A: begin
            if (accept) begin
               in0_nxt   = op_data;
               state_nxt = LOAD_B;
            end
         end
         LOAD_B: begin
            if (accept) begin
               in1_nxt   = op_data;
               state_nxt = EXEC;
            end
         end
         EXEC: begin
            res_nxt   = alu_out;
            rv_nxt    = 1'b1;
            state_nxt = HOLD;
         end
         HOLD: begin
            if (res_valid && res_ready) begin
               rv_nxt    = 1'b0;
               cnt_nxt   = txn_count + 8'd1;
               state_nxt = LOAD_A;
            end
         end
         default: state_nxt = LOAD_A;
      endcase
   end

endmodule
